// File: rtl/mult_18x18_bist_ctrl_if.sv
// Operand/product bus between the BIST sequencer and the 18x18 multiplier slice.
// No valid/ready pair: operands count as driven only while bist_own=1, and the slice returns Y a fixed latency later.
interface mult_18x18_bist_ctrl_if;
  logic [0:17] mult_A_out;
  logic [0:17] mult_B_out;
  logic [0:35] mult_Y_in;
  logic        bist_own;

  modport master (
    output mult_A_out,
    output mult_B_out,
    output bist_own,
    input  mult_Y_in
  );

  modport slave (
    input  mult_A_out,
    input  mult_B_out,
    input  bist_own,
    output mult_Y_in
  );
endinterface

// File: rtl/mult_18x18_bist_ctrl.sv
// BIST sequencer for the mult_18 slice: LFSR operand generation, MISR product
// compaction and a final golden-signature compare.
module mult_18x18_bist_ctrl #(
  parameter int          NUM_VECTORS  = 256,
  parameter int          MULT_LATENCY = 0,
  parameter logic [17:0] SEED_A       = 18'h2AAAA,
  parameter logic [17:0] SEED_B       = 18'h15555,
  parameter logic [35:0] GOLDEN_SIG   = 36'h0
) (
  input  logic                          prog_clk,
  input  logic                          pReset_n,
  input  logic                          bist_start,
  input  logic                          bist_abort,
  mult_18x18_bist_ctrl_if.master        slice,
  output logic                          bist_busy,
  output logic                          bist_done,
  output logic                          bist_pass,
  output logic [0:35]                   bist_signature,
  output logic [0:15]                   vec_count,
  output logic [2:0]                    bist_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRIVE   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [15:0] VEC_TOTAL  = 16'(NUM_VECTORS);
  localparam logic [15:0] VEC_LAST   = 16'(NUM_VECTORS - 1);
  localparam logic [1:0]  LAT_LAST   = 2'((MULT_LATENCY == 0) ? 0 : MULT_LATENCY - 1);
  localparam logic [2:0]  TAP_MASK   = 3'((4'b0001 << MULT_LATENCY) >> 1);
  localparam bit          COMB_SLICE = (MULT_LATENCY == 0);

  logic [2:0]  state;
  logic [17:0] lfsr_a;
  logic [17:0] lfsr_b;
  logic [35:0] misr;
  logic [15:0] vec_cnt;
  logic [15:0] cap_cnt;
  logic        pass_q;
  logic [2:0]  cap_pipe;
  logic [1:0]  lat_cnt;

  logic        own;
  logic        drive_fire;
  logic        last_drive;
  logic        capture;
  logic [35:0] product;
  logic [35:0] misr_next;

  function automatic logic [17:0] lfsr_step(input logic [17:0] v);
    return {v[16:0], v[17] ^ v[10]};
  endfunction

  assign own        = (state == S_DRIVE) || (state == S_DRAIN);
  assign drive_fire = (state == S_DRIVE);
  assign last_drive = drive_fire && (vec_cnt == VEC_LAST);
  assign product    = slice.mult_Y_in;
  assign misr_next  = {misr[34:0], misr[35] ^ misr[24]} ^ product;

  // A combinational slice folds on the drive edge itself; otherwise the pipe tap
  // marks the edge MULT_LATENCY cycles later. The count cap guards against over-capture.
  assign capture = (COMB_SLICE ? drive_fire : |(cap_pipe & TAP_MASK)) &&
                   (cap_cnt < VEC_TOTAL);

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state    <= S_IDLE;
      lfsr_a   <= SEED_A;
      lfsr_b   <= SEED_B;
      misr     <= '0;
      vec_cnt  <= '0;
      cap_cnt  <= '0;
      pass_q   <= 1'b0;
      cap_pipe <= '0;
      lat_cnt  <= '0;
    end else if (bist_abort) begin
      // Signature is deliberately kept so a debugger can read where the run stopped.
      state    <= S_IDLE;
      lfsr_a   <= SEED_A;
      lfsr_b   <= SEED_B;
      vec_cnt  <= '0;
      cap_cnt  <= '0;
      pass_q   <= 1'b0;
      cap_pipe <= '0;
      lat_cnt  <= '0;
    end else begin
      cap_pipe <= {cap_pipe[1:0], drive_fire};
      if (capture) begin
        misr    <= misr_next;
        cap_cnt <= cap_cnt + 16'd1;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (bist_start) begin
            lfsr_a  <= SEED_A;
            lfsr_b  <= SEED_B;
            misr    <= '0;
            vec_cnt <= '0;
            cap_cnt <= '0;
            pass_q  <= 1'b0;
            state   <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (vec_cnt < VEC_TOTAL) vec_cnt <= vec_cnt + 16'd1;
          if (last_drive) begin
            lat_cnt <= '0;
            state   <= COMB_SLICE ? S_COMPARE : S_DRAIN;
          end else begin
            // The last vector is not stepped past, so DRAIN keeps it on the bus.
            lfsr_a <= lfsr_step(lfsr_a);
            lfsr_b <= lfsr_step(lfsr_b);
          end
        end
        S_DRAIN: begin
          if (lat_cnt == LAT_LAST) state <= S_COMPARE;
          else lat_cnt <= lat_cnt + 2'd1;
        end
        S_COMPARE: begin
          pass_q <= (misr == GOLDEN_SIG);
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign slice.mult_A_out = own ? lfsr_a : '0;
  assign slice.mult_B_out = own ? lfsr_b : '0;
  assign slice.bist_own   = own;
  assign bist_busy        = own;
  assign bist_done        = (state == S_DONE);
  assign bist_pass        = pass_q && (state == S_DONE);
  assign bist_signature   = misr;
  assign vec_count        = vec_cnt;
  assign bist_state       = state;

endmodule
